// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder-sharing arbiter (adder_share_arb).
package adder_arb_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    localparam int DEFAULT_WIDTH = 64;

    // Index width for n items, never narrower than one bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               found
);

    always_comb begin
        logic [IDW-1:0] j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sequencer sharing one registered adder among NUM_REQ requesters.
// Define ADDARB_OVF_EN to compute rsp_ovf (signed overflow); otherwise it is tied low.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int WIDTH       = DEFAULT_WIDTH,
    parameter  int ADD_LATENCY = 1,
    localparam int IDW         = idw(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    localparam int LCW = idw(ADD_LATENCY);

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       op_id;
    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] op_b;
    logic                 op_cin;
    logic [LCW-1:0]       lat_cnt;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       win_idx;
    logic                 win_found;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .found (win_found)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign add_a     = op_a;
    assign add_b     = op_b;
    assign add_cin   = op_cin;

`ifdef ADDARB_OVF_EN
    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction
`else
    assign rsp_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                // Only the winner's operand slice is ever sampled.
                IDLE: begin
                    if (win_found) begin
                        op_a   <= req_a[win_idx*WIDTH +: WIDTH];
                        op_b   <= req_b[win_idx*WIDTH +: WIDTH];
                        op_cin <= req_cin[win_idx];
                        op_id  <= win_idx;
                        rr_ptr <= win_idx;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    lat_cnt <= LCW'(ADD_LATENCY - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_id    <= op_id;
`ifdef ADDARB_OVF_EN
                        rsp_ovf   <= signed_ovf(op_a, op_b, add_sum);
`endif
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb with a behavioural adder and a reference model.
module tb_adder_share_arb;

    localparam int N    = 4;
    localparam int W    = 64;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_cin = '0;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic           rsp_valid, rsp_cout, rsp_ovf;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;

    logic [1:0]     v3 = '0;
    logic [1:0]     rdy3;
    logic [2*W-1:0] a3 = '0;
    logic [2*W-1:0] b3 = '0;
    logic [1:0]     cin3 = '0;
    logic [W-1:0]   add_a3, add_b3, add_sum3;
    logic           add_cin3, add_cout3;
    logic           rsp_valid3, rsp_cout3, rsp_ovf3;
    logic           rsp_ready3 = 1'b1;
    logic [0:0]     rsp_id3;
    logic [W-1:0]   rsp_sum3;

    adder_share_arb #(.NUM_REQ(N), .WIDTH(W), .ADD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    adder_share_arb #(.NUM_REQ(2), .WIDTH(W), .ADD_LATENCY(LAT3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_cin(cin3),
        .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_sum(add_sum3), .add_cout(add_cout3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3), .rsp_ovf(rsp_ovf3)
    );

    // Behavioural shared adders: one register stage, and three stages.
    always_ff @(posedge clk)
        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

    logic [W:0] s3_0, s3_1, s3_2;
    always_ff @(posedge clk) begin
        s3_0 <= {1'b0, add_a3} + {1'b0, add_b3} + {64'd0, add_cin3};
        s3_1 <= s3_0;
        s3_2 <= s3_1;
    end
    assign {add_cout3, add_sum3} = s3_2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_win = N - 1;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] s);
        logic o;
        o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`ifndef ADDARB_OVF_EN
        o = 1'b0;
`endif
        return o;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        if (c) req_cin = req_cin | (N'(1) << i);
        else   req_cin = req_cin & ~(N'(1) << i);
    endtask

    task automatic rand_op(input int i);
        set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    logic [W-1:0] last_sum;

    // One transaction: grant check, operand capture, response latency and payload.
    task automatic do_txn(input bit keep, output int gcyc);
        int t, e;
        logic [W-1:0] ea, eb;
        logic ec;
        logic [W:0] res;
        e = pick(req_valid, last_win);
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            step();
            #1;
            t++;
        end
        chk("grant_seen", (W+1)'(req_ready != '0), (W+1)'(1));
        chk("grant_onehot", (W+1)'(req_ready), (W+1)'(N'(1) << e));
        gcyc = cyc;
        ea = req_a[e*W +: W];
        eb = req_b[e*W +: W];
        ec = 1'((req_cin >> e) & 1);
        res = {1'b0, ea} + {1'b0, eb} + {64'd0, ec};
        last_win = e;
        step();
        chk("ready_pulse", (W+1)'(req_ready), '0);
        if (keep) rand_op(e);
        else req_valid = req_valid & ~(N'(1) << e);
        t = 0;
        while (!rsp_valid && t < 20) begin
            step();
            t++;
        end
        chk("rsp_latency", (W+1)'(t), (W+1)'(LAT + 1));
        chk("rsp_sum", (W+1)'(rsp_sum), (W+1)'(res[W-1:0]));
        chk("rsp_cout", (W+1)'(rsp_cout), (W+1)'(res[W]));
        chk("rsp_id", (W+1)'(rsp_id), (W+1)'(e));
        chk("rsp_ovf", (W+1)'(rsp_ovf), (W+1)'(model_ovf(ea, eb, res[W-1:0])));
        last_sum = res[W-1:0];
    endtask

    initial begin
        int g, gprev, t;
        logic [N-1:0] m;

        // Reset state
        step(); step();
        chk("rst_req_ready", (W+1)'(req_ready), '0);
        chk("rst_rsp_valid", (W+1)'(rsp_valid), '0);
        chk("rst_rsp_sum", (W+1)'(rsp_sum), '0);
        chk("rst_rsp_id", (W+1)'(rsp_id), '0);
        chk("rst_add_a", (W+1)'(add_a), '0);
        chk("rst_add_cin", (W+1)'(add_cin), '0);
        chk("rst_ready3", (W+1)'(rdy3), '0);
        rst = 1'b0;

        // Single request, carry out of all-ones + 1
        set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        req_valid = 4'b0001;
        do_txn(1'b0, g);
        step();

        // Round-robin under full load from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        last_win = N - 1;
        for (int i = 0; i < N; i++) rand_op(i);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        gprev = 0;
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b1, g);
            chk("rr_order", (W+1)'(last_win), (W+1)'(i % N));
            if (i > 0) chk("issue_interval", (W+1)'(g - gprev), (W+1)'(LAT + 3));
            gprev = g;
        end
        req_valid = '0;
        step();

        // Response backpressure with req1 pending
        rand_op(0);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        do_txn(1'b0, g);
        rand_op(1);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", (W+1)'(rsp_valid), (W+1)'(1));
            chk("bp_sum_stable", (W+1)'(rsp_sum), (W+1)'(last_sum));
            chk("bp_no_ready", (W+1)'(req_ready), '0);
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("bp_next_grant", (W+1)'(req_ready), (W+1)'(4'b0010));
        do_txn(1'b0, g);
        step();

        // Signed overflow boundary
        set_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        req_valid = 4'b0100;
        do_txn(1'b0, g);
        chk("ovf_sum", (W+1)'(rsp_sum), (W+1)'(64'h8000_0000_0000_0000));
        step();

        // Randomized masks
        for (int i = 0; i < 8; i++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) rand_op(k);
            req_valid = m;
            do_txn(1'b0, g);
            req_valid = '0;
            step();
        end

        // Reset while waiting on the adder
        rand_op(0);
        req_valid = 4'b0001;
        do_txn(1'b0, g);
        step();
        rand_op(3);
        req_valid = 4'b1000;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin step(); #1; t++; end
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_rsp_valid", (W+1)'(rsp_valid), '0);
        chk("midrst_req_ready", (W+1)'(req_ready), '0);
        chk("midrst_rsp_sum", (W+1)'(rsp_sum), '0);
        step(); step(); step();
        chk("midrst_discarded", (W+1)'(rsp_valid), '0);
        last_win = N - 1;
        rand_op(0); rand_op(2);
        req_valid = 4'b0101;
        do_txn(1'b0, g);
        chk("midrst_first", (W+1)'(last_win), '0);
        do_txn(1'b0, g);
        chk("midrst_second", (W+1)'(last_win), (W+1)'(2));
        step();

        // Three-cycle adder latency instance
        a3[W-1:0] = 64'h1234;
        b3[W-1:0] = 64'h4321;
        v3 = 2'b01;
        t = 0;
        #1;
        while (rdy3 == '0 && t < 20) begin step(); #1; t++; end
        chk("lat3_grant", (W+1)'(rdy3), (W+1)'(2'b01));
        step();
        v3 = '0;
        t = 0;
        while (!rsp_valid3 && t < 20) begin step(); t++; end
        chk("lat3_latency", (W+1)'(t), (W+1)'(LAT3 + 1));
        chk("lat3_sum", (W+1)'(rsp_sum3), (W+1)'(64'h5555));
        chk("lat3_cout", (W+1)'(rsp_cout3), '0);
        chk("lat3_id", (W+1)'(rsp_id3), '0);
        chk("lat3_ovf", (W+1)'(rsp_ovf3), '0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
